// File: rtl/multi_edge_detect.sv
// multi_edge_detect: N-channel edge detector for asynchronous level inputs.
// Every channel has its own synchroniser and previous-value register, and a mode
// that selects rising, falling, both or no edges. Each channel also keeps a
// registered one-cycle tick with its direction, a sticky pending flag and a
// saturating event counter. The pending flags that are enabled combine into irq.
module multi_edge_detect #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int SEL_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       level,
    input  logic [2*N-1:0]     mode,
    input  logic [N-1:0]       pend_clr,
    input  logic [N-1:0]       irq_en,
    input  logic [N-1:0]       cnt_clr,
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [N-1:0]       tick,
    output logic [N-1:0]       dir,
    output logic [N-1:0]       pending,
    output logic [CNT_W-1:0]   cnt_out,
    output logic               irq
);

    // Per-channel counter values, gathered here for the output mux
    logic [CNT_W-1:0] cnt_arr [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi = gi + 1) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   tick_reg;
            logic                   dir_reg;
            logic                   pending_reg;
            logic [CNT_W-1:0]       cnt_reg;

            logic                   sync_last;
            logic                   rise;
            logic                   fall;
            logic                   ev;
            logic                   pending_next;
            logic [CNT_W-1:0]       cnt_next;

            // The edge compare uses the last sync stage only, so that the
            // metastable first stage never reaches the detection logic.
            assign sync_last = sync_reg[SYNC_STAGES-1];
            assign rise      = sync_last & ~prev_reg;
            assign fall      = ~sync_last & prev_reg;
            // The mode is applied here, after the edge detection. In mode 00
            // the sync chain and prev_reg keep tracking the input, so a
            // channel that is enabled again does not report an old edge.
            assign ev        = (rise & mode[2*gi]) | (fall & mode[2*gi+1]);

            // Next state of the pending flag and the counter. A new event wins
            // over a clear in the same cycle.
            always_comb begin
                pending_next = (pending_reg & ~pend_clr[gi]) | ev;
                cnt_next     = cnt_reg;
                if (cnt_clr[gi]) begin
                    cnt_next = ev ? CNT_W'(1) : '0;
                end else if (ev && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // Channel state registers. Reset clears them at once, so edges that
            // are still in flight are dropped.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_reg    <= '0;
                    prev_reg    <= 1'b0;
                    tick_reg    <= 1'b0;
                    dir_reg     <= 1'b0;
                    pending_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], level[gi]};
                    prev_reg    <= sync_last;
                    tick_reg    <= ev;
                    if (ev) begin
                        dir_reg <= rise;
                    end
                    pending_reg <= pending_next;
                    cnt_reg     <= cnt_next;
                end
            end

            assign tick[gi]    = tick_reg;
            assign dir[gi]     = dir_reg;
            assign pending[gi] = pending_reg;
            assign cnt_arr[gi] = cnt_reg;
        end
    endgenerate

    // Counter read-back mux. A select value with no matching channel gives 0.
    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                cnt_out = cnt_arr[i];
            end
        end
    end

    // irq is driven only by registers and irq_en, so level cannot glitch it.
    assign irq = |(pending & irq_en);

endmodule
